seq_serializer: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the sequence detector and drives its serial bit input.
- Accepts WIDTH-bit words through a valid/ready handshake.
- Shifts each word out one bit per clock, MSB first.
- Drives 0 when idle, so the detector sees no spurious 1s between words.

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_serializer.sv | 122 ++++++++++++
 tb/tb_seq_serializer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer and the sequence detector bench.
package seq_pkg;

  localparam int unsigned SEQ_WORD_W = 8;

  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_SHIFT  = 2'd1,
    SER_PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detector, MSB first, 0 when idle.
// Optional trailing even-parity bit when SEQ_SER_PARITY_EN is defined.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WORD_W,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  ser_state_t       st_q, st_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;
  logic             reload;
  logic             ser_out_d, ser_valid_d, word_done_d, load_ready_d, busy_d;
`ifdef SEQ_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // load_ready is a register, so the handshake has no load_valid->load_ready path
  assign xfer = load_valid && load_ready;

  // Next state, datapath and next-cycle output values
  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    reload = 1'b0;
`ifdef SEQ_SER_PARITY_EN
    par_d  = par_q;
`endif
    case (st_q)
      SER_IDLE: begin
        reload = xfer;
      end
      SER_SHIFT: begin
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef SEQ_SER_PARITY_EN
          st_d = SER_PARITY;
`else
          st_d   = SER_IDLE;
          reload = xfer;
`endif
        end
      end
`ifdef SEQ_SER_PARITY_EN
      SER_PARITY: begin
        st_d   = SER_IDLE;
        reload = xfer;
      end
`endif
      default: begin
        st_d  = SER_IDLE;
        sh_d  = '0;
        cnt_d = '0;
      end
    endcase

    if (reload) begin
      st_d  = SER_SHIFT;
      sh_d  = load_data;
      cnt_d = CNT_W'(WIDTH);
`ifdef SEQ_SER_PARITY_EN
      par_d = ^load_data;
`endif
    end

    ser_valid_d = (st_d != SER_IDLE);
    busy_d      = (st_d == SER_SHIFT);
    ser_out_d   = (st_d == SER_SHIFT) ? sh_d[WIDTH-1] : 1'b0;
`ifdef SEQ_SER_PARITY_EN
    if (st_d == SER_PARITY) ser_out_d = par_d;
    word_done_d = (st_d == SER_PARITY);
`else
    word_done_d = (st_d == SER_SHIFT) && (cnt_d == CNT_W'(1));
`endif
    load_ready_d = (st_d == SER_IDLE) || word_done_d;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= SER_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      word_done  <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      st_q       <= st_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      word_done  <= word_done_d;
      busy       <= busy_d;
      load_ready <= load_ready_d;
    end
  end

`ifdef SEQ_SER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_seq_serializer.sv
// Directed self-checking bench for seq_serializer (WIDTH=8).
module tb_seq_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       word_done;
  logic       busy;

  int checks;
  int failures;

  seq_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00;
    step(); step();
    checks++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ser_valid=%b ser_out=%b busy=%b word_done=%b, want all 0",
               ser_valid, ser_out, busy, word_done);
    end
    rst = 1'b0;
    step();
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got load_ready=%b want 1", load_ready);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hB0;
    load_valid = 1'b1; load_data = w;
    step();
    load_valid = 1'b0; load_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== w[7-i] || ser_valid !== 1'b1 || busy !== 1'b1 ||
          word_done !== (i == 7) || load_ready !== (i == 7)) begin
        failures++;
        $display("FAIL single_bit%0d: got out=%b v=%b busy=%b done=%b rdy=%b, want out=%b v=1 busy=1 done=%b rdy=%b",
                 i, ser_out, ser_valid, busy, word_done, load_ready, w[7-i], (i == 7), (i == 7));
      end
      step();
    end
    checks++;
    if (ser_out !== 1'b0 || ser_valid !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle: got out=%b v=%b busy=%b done=%b rdy=%b, want 0 0 0 0 1",
               ser_out, ser_valid, busy, word_done, load_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int          dones;
    stream = '0; dones = 0;
    load_valid = 1'b1; load_data = 8'h0B;
    step();
    load_data = 8'hB0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) load_valid = 1'b0;
      stream = {stream[14:0], ser_out};
      if (word_done === 1'b1) dones++;
      checks++;
      if (ser_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid%0d: got ser_valid=%b want 1", i, ser_valid);
      end
      step();
    end
    checks++;
    if (stream !== 16'h0BB0) begin
      failures++;
      $display("FAIL b2b_stream: got %h want 0bb0", stream);
    end
    checks++;
    if (dones !== 2) begin
      failures++;
      $display("FAIL b2b_done_count: got %0d want 2", dones);
    end
    checks++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got v=%b out=%b want 0 0", ser_valid, ser_out);
    end
  endtask

  task automatic test_hold_valid();
    logic [15:0] stream;
    stream = '0;
    load_valid = 1'b1; load_data = 8'h5A;
    step();
    for (int i = 0; i < 16; i++) begin
      // junk on load_data while not ready must never be captured
      load_data = (i == 7) ? 8'hC3 : 8'(8'hE7 ^ i);
      if (i == 15) load_valid = 1'b0;
      stream = {stream[14:0], ser_out};
      checks++;
      if (load_ready !== ((i % 8) == 7)) begin
        failures++;
        $display("FAIL hold_ready%0d: got load_ready=%b want %b", i, load_ready, ((i % 8) == 7));
      end
      step();
    end
    checks++;
    if (stream !== 16'h5AC3) begin
      failures++;
      $display("FAIL hold_stream: got %h want 5ac3", stream);
    end
    checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_single_xfer: got busy=%b v=%b want 0 0", busy, ser_valid);
    end
    load_data = 8'h00;
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    load_valid = 1'b1; load_data = 8'hFF;
    step();
    load_valid = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ser_out !== 1'b0 || busy !== 1'b0 || ser_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst: got out=%b busy=%b v=%b want 0 0 0", ser_out, busy, ser_valid);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_release: got rdy=%b busy=%b want 1 0", load_ready, busy);
    end
    w = 8'h80;
    load_valid = 1'b1; load_data = w;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== w[7-i] || ser_valid !== 1'b1) begin
        failures++;
        $display("FAIL post_rst_bit%0d: got out=%b v=%b want out=%b v=1", i, ser_out, ser_valid, w[7-i]);
      end
      step();
    end
  endtask

`ifdef SEQ_SER_PARITY_EN
  task automatic test_parity();
    logic [7:0] words [2];
    logic       par   [2];
    words[0] = 8'hB0; par[0] = 1'b1;
    words[1] = 8'h03; par[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1; load_data = words[k];
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ser_out !== words[k][7-i] || word_done !== 1'b0) begin
          failures++;
          $display("FAIL par_w%0d_bit%0d: got out=%b done=%b want out=%b done=0",
                   k, i, ser_out, word_done, words[k][7-i]);
        end
        step();
      end
      checks++;
      if (ser_out !== par[k] || ser_valid !== 1'b1 || word_done !== 1'b1 || load_ready !== 1'b1) begin
        failures++;
        $display("FAIL par_w%0d_bit: got out=%b v=%b done=%b rdy=%b want out=%b v=1 done=1 rdy=1",
                 k, ser_out, ser_valid, word_done, load_ready, par[k]);
      end
      step();
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    test_reset();
`ifdef SEQ_SER_PARITY_EN
    test_parity();
`else
    test_single_word();
    test_back_to_back();
    test_hold_valid();
    test_async_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
